// File: rtl/prog_load_check_if.sv
// Load stream, imem write port and dmem store monitor for prog_load_check.
// master = host/CPU environment side, slave = the sequencer.
interface prog_load_check_if #(
  parameter int IW  = 32,
  parameter int IAW = 10,
  parameter int DW  = 48,
  parameter int DAW = 10
);
  logic           load_valid;
  logic           load_ready;
  logic [IW-1:0]  load_data;
  logic           load_last;

  logic           imem_we;
  logic [IAW-1:0] imem_addr;
  logic [IW-1:0]  imem_wdata;

  logic           dmem_we;
  logic [DAW-1:0] dmem_addr;
  logic [DW-1:0]  dmem_wdata;

  modport master (
    output load_valid, load_data, load_last,
    output dmem_we, dmem_addr, dmem_wdata,
    input  load_ready,
    input  imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  load_valid, load_data, load_last,
    input  dmem_we, dmem_addr, dmem_wdata,
    output load_ready,
    output imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/prog_load_check.sv
// Program-load and result-check sequencer: streams a program into imem with
// the CPU held in reset, then runs the CPU and watches dmem for a target store.
module prog_load_check #(
  parameter int             IW        = 32,
  parameter int             IAW       = 10,
  parameter logic [IAW-1:0] BASE_ADDR = 10'h200,
  parameter int             DW        = 48,
  parameter int             DAW       = 10,
  parameter int             CW        = 16,
  parameter int             TIMEOUT   = 1000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [DAW-1:0]      expect_addr,
  input  logic [DW-1:0]       expect_data,
  prog_load_check_if.slave    bus,
  output logic                cpu_rst,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic                timeout,
  output logic [CW-1:0]       cycle_count,
  output logic [IAW-1:0]      load_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DONE
  } state_t;

  state_t         state_q,       state_d;
  logic           load_ready_q,  load_ready_d;
  logic           imem_we_q,     imem_we_d;
  logic [IAW-1:0] imem_addr_q,   imem_addr_d;
  logic [IW-1:0]  imem_wdata_q,  imem_wdata_d;
  logic           cpu_rst_q,     cpu_rst_d;
  logic           busy_q,        busy_d;
  logic           done_q,        done_d;
  logic           pass_q,        pass_d;
  logic           timeout_q,     timeout_d;
  logic [CW-1:0]  cycle_count_q, cycle_count_d;
  logic [IAW-1:0] load_count_q,  load_count_d;
  logic [DAW-1:0] exp_addr_q,    exp_addr_d;
  logic [DW-1:0]  exp_data_q,    exp_data_d;

  logic           xfer;
  logic           hit;
  logic [CW-1:0]  run_cnt;

  assign xfer    = bus.load_valid & load_ready_q;
  assign hit     = bus.dmem_we && (bus.dmem_addr == exp_addr_q);
  assign run_cnt = cycle_count_q + CW'(1);

  always_comb begin
    // NOTE: every _d starts from its _q (and imem_we from 0) so no path
    // through the case leaves a signal unassigned and infers a latch.
    state_d       = state_q;
    load_ready_d  = load_ready_q;
    imem_we_d     = 1'b0;
    imem_addr_d   = imem_addr_q;
    imem_wdata_d  = imem_wdata_q;
    cpu_rst_d     = cpu_rst_q;
    busy_d        = busy_q;
    done_d        = done_q;
    pass_d        = pass_q;
    timeout_d     = timeout_q;
    cycle_count_d = cycle_count_q;
    load_count_d  = load_count_q;
    exp_addr_d    = exp_addr_q;
    exp_data_d    = exp_data_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d       = S_LOAD;
          exp_addr_d    = expect_addr;
          exp_data_d    = expect_data;
          done_d        = 1'b0;
          pass_d        = 1'b0;
          timeout_d     = 1'b0;
          cycle_count_d = '0;
          load_count_d  = '0;
          imem_addr_d   = BASE_ADDR;
          cpu_rst_d     = 1'b1;
          load_ready_d  = 1'b1;
          busy_d        = 1'b1;
        end
      end

      S_LOAD: begin
        if (xfer) begin
          imem_we_d    = 1'b1;
          imem_addr_d  = BASE_ADDR + load_count_q;  // wraps modulo 2^IAW
          imem_wdata_d = bus.load_data;
          load_count_d = load_count_q + IAW'(1);
          if (bus.load_last) begin
            state_d      = S_RUN;
            load_ready_d = 1'b0;
            cpu_rst_d    = 1'b0;
          end
        end
      end

      S_RUN: begin
        cycle_count_d = run_cnt;
        // A matching store wins over a timeout landing on the same cycle.
        if (hit) begin
          state_d   = S_DONE;
          pass_d    = (bus.dmem_wdata == exp_data_q);
          timeout_d = 1'b0;
          done_d    = 1'b1;
          busy_d    = 1'b0;
          cpu_rst_d = 1'b1;
        end else if (run_cnt == CW'(TIMEOUT)) begin
          state_d   = S_DONE;
          pass_d    = 1'b0;
          timeout_d = 1'b1;
          done_d    = 1'b1;
          busy_d    = 1'b0;
          cpu_rst_d = 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      load_ready_q  <= 1'b0;
      imem_we_q     <= 1'b0;
      imem_addr_q   <= BASE_ADDR;
      imem_wdata_q  <= '0;
      cpu_rst_q     <= 1'b1;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
      timeout_q     <= 1'b0;
      cycle_count_q <= '0;
      load_count_q  <= '0;
      exp_addr_q    <= '0;
      exp_data_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge
      // values, independent of statement order.
      state_q       <= state_d;
      load_ready_q  <= load_ready_d;
      imem_we_q     <= imem_we_d;
      imem_addr_q   <= imem_addr_d;
      imem_wdata_q  <= imem_wdata_d;
      cpu_rst_q     <= cpu_rst_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      pass_q        <= pass_d;
      timeout_q     <= timeout_d;
      cycle_count_q <= cycle_count_d;
      load_count_q  <= load_count_d;
      exp_addr_q    <= exp_addr_d;
      exp_data_q    <= exp_data_d;
    end
  end

  assign bus.load_ready = load_ready_q;
  assign bus.imem_we    = imem_we_q;
  assign bus.imem_addr  = imem_addr_q;
  assign bus.imem_wdata = imem_wdata_q;
  assign cpu_rst        = cpu_rst_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign timeout        = timeout_q;
  assign cycle_count    = cycle_count_q;
  assign load_count     = load_count_q;

endmodule

// File: tb/tb_prog_load_check.sv
// Bench for prog_load_check: two instances (base 0x200/timeout 50 and
// base 0x3FE/timeout 1000) driven by a modelled host and CPU store stream.
module tb_prog_load_check;
  localparam int IW  = 32;
  localparam int IAW = 10;
  localparam int DW  = 48;
  localparam int DAW = 10;
  localparam int CW  = 16;
  localparam int TO_A = 50;
  localparam int TO_B = 1000;
  localparam logic [IAW-1:0] BASE_A = 10'h200;
  localparam logic [IAW-1:0] BASE_B = 10'h3FE;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]          start_v;
  logic [1:0][DAW-1:0] ea_v;
  logic [1:0][DW-1:0]  ed_v;
  logic [1:0]          cpu_rst_v, busy_v, done_v, pass_v, to_v;
  logic [1:0][CW-1:0]  cc_v;
  logic [1:0][IAW-1:0] lc_v;

  prog_load_check_if #(.IW(IW), .IAW(IAW), .DW(DW), .DAW(DAW)) bus_a ();
  prog_load_check_if #(.IW(IW), .IAW(IAW), .DW(DW), .DAW(DAW)) bus_b ();

  prog_load_check #(.IW(IW), .IAW(IAW), .BASE_ADDR(BASE_A), .DW(DW), .DAW(DAW),
                    .CW(CW), .TIMEOUT(TO_A)) dut_a (
    .clk(clk), .reset(rst_n), .start(start_v[0]),
    .expect_addr(ea_v[0]), .expect_data(ed_v[0]), .bus(bus_a.slave),
    .cpu_rst(cpu_rst_v[0]), .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]),
    .timeout(to_v[0]), .cycle_count(cc_v[0]), .load_count(lc_v[0])
  );

  prog_load_check #(.IW(IW), .IAW(IAW), .BASE_ADDR(BASE_B), .DW(DW), .DAW(DAW),
                    .CW(CW), .TIMEOUT(TO_B)) dut_b (
    .clk(clk), .reset(rst_n), .start(start_v[1]),
    .expect_addr(ea_v[1]), .expect_data(ed_v[1]), .bus(bus_b.slave),
    .cpu_rst(cpu_rst_v[1]), .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]),
    .timeout(to_v[1]), .cycle_count(cc_v[1]), .load_count(lc_v[1])
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Program image, CPU store schedule (indexed by run cycle) and observed imem writes.
  logic [IW-1:0]  prog_q[$];
  bit             sch_we  [0:TO_B+8];
  logic [DAW-1:0] sch_addr[0:TO_B+8];
  logic [DW-1:0]  sch_data[0:TO_B+8];
  logic [IAW+IW-1:0] wq0[$];
  logic [IAW+IW-1:0] wq1[$];

  always @(negedge clk) if (bus_a.imem_we === 1'b1) wq0.push_back({bus_a.imem_addr, bus_a.imem_wdata});
  always @(negedge clk) if (bus_b.imem_we === 1'b1) wq1.push_back({bus_b.imem_addr, bus_b.imem_wdata});

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_load(input int s, input logic v, input logic [IW-1:0] d, input logic l);
    if (s == 0) begin bus_a.load_valid = v; bus_a.load_data = d; bus_a.load_last = l; end
    else        begin bus_b.load_valid = v; bus_b.load_data = d; bus_b.load_last = l; end
  endtask

  task automatic set_dmem(input int s, input logic we, input logic [DAW-1:0] a, input logic [DW-1:0] d);
    if (s == 0) begin bus_a.dmem_we = we; bus_a.dmem_addr = a; bus_a.dmem_wdata = d; end
    else        begin bus_b.dmem_we = we; bus_b.dmem_addr = a; bus_b.dmem_wdata = d; end
  endtask

  function automatic logic f_ready(input int s);
    return (s == 0) ? bus_a.load_ready : bus_b.load_ready;
  endfunction
  function automatic logic f_we(input int s);
    return (s == 0) ? bus_a.imem_we : bus_b.imem_we;
  endfunction
  function automatic logic [IAW-1:0] f_addr(input int s);
    return (s == 0) ? bus_a.imem_addr : bus_b.imem_addr;
  endfunction
  function automatic logic [IW-1:0] f_wdata(input int s);
    return (s == 0) ? bus_a.imem_wdata : bus_b.imem_wdata;
  endfunction

  task automatic check_reset(input int s, input string tag);
    check({tag, ".rst_cpu_rst"},    cpu_rst_v[s], 1);
    check({tag, ".rst_load_ready"}, f_ready(s), 0);
    check({tag, ".rst_imem_we"},    f_we(s), 0);
    check({tag, ".rst_imem_addr"},  f_addr(s), (s == 0) ? BASE_A : BASE_B);
    check({tag, ".rst_imem_wdata"}, f_wdata(s), 0);
    check({tag, ".rst_busy"},       busy_v[s], 0);
    check({tag, ".rst_done"},       done_v[s], 0);
    check({tag, ".rst_pass"},       pass_v[s], 0);
    check({tag, ".rst_timeout"},    to_v[s], 0);
    check({tag, ".rst_cycle_cnt"},  cc_v[s], 0);
    check({tag, ".rst_load_cnt"},   lc_v[s], 0);
  endtask

  task automatic fill_prog(input int n);
    prog_q.delete();
    for (int i = 0; i < n; i++) prog_q.push_back($urandom);
  endtask

  // mode 0: store ea<=store_val at hit_k; mode 2: never store to ea.
  // Random stores to other addresses are sprinkled over every cycle.
  task automatic build_sched(input logic [DAW-1:0] ea, input logic [DW-1:0] store_val,
                             input int mode, input int hit_k);
    for (int k = 0; k <= TO_B + 8; k++) begin
      logic [DAW-1:0] a;
      a = DAW'($urandom);
      if (a == ea) a = a ^ DAW'(1);
      sch_we[k]   = ($urandom_range(0, 3) == 0);
      sch_addr[k] = a;
      sch_data[k] = DW'({$urandom, $urandom});
    end
    if (mode != 2) begin
      sch_we[hit_k]   = 1'b1;
      sch_addr[hit_k] = ea;
      sch_data[hit_k] = store_val;
    end
  endtask

  task automatic session(input int s, input int gap_mode, input logic [DAW-1:0] ea,
                         input logic [DW-1:0] ed, input int rst_at, input int start_at,
                         input string tag);
    int to, idx, cyc, k, bad_rst, exp_cyc, nw;
    bit v, exp_pass, exp_to, aborted;
    logic [IAW+IW-1:0] w;
    logic [IAW-1:0] exp_addr;

    to = (s == 0) ? TO_A : TO_B;
    // Outcome: first store to ea within the timeout decides, else timeout.
    exp_pass = 1'b0; exp_to = 1'b1; exp_cyc = to;
    for (int j = 1; j <= to; j++) begin
      if (sch_we[j] && sch_addr[j] == ea) begin
        exp_pass = (sch_data[j] == ed); exp_to = 1'b0; exp_cyc = j;
        break;
      end
    end

    if (s == 0) wq0.delete(); else wq1.delete();
    start_v[s] = 1'b1; ea_v[s] = ea; ed_v[s] = ed;
    @(negedge clk);
    start_v[s] = 1'b0; ea_v[s] = ~ea; ed_v[s] = ~ed;
    check({tag, ".busy_load"},  busy_v[s], 1);
    check({tag, ".ready_load"}, f_ready(s), 1);
    check({tag, ".done_load"},  done_v[s], 0);
    check({tag, ".lc_start"},   lc_v[s], 0);
    check({tag, ".cc_start"},   cc_v[s], 0);

    idx = 0; cyc = 0; bad_rst = 0;
    while (idx < prog_q.size() && cyc < 2000) begin
      case (gap_mode)
        0:       v = 1'b1;
        1:       v = (cyc % 2 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      set_load(s, v, v ? prog_q[idx] : IW'($urandom),
               v ? (idx == prog_q.size() - 1) : 1'($urandom_range(0, 1)));
      start_v[s] = (cyc == start_at);
      if (cpu_rst_v[s] !== 1'b1) bad_rst++;
      if (v && f_ready(s)) idx++;
      @(negedge clk);
      cyc++;
    end
    set_load(s, 1'b0, '0, 1'b0);
    start_v[s] = 1'b0;
    check({tag, ".load_bound"}, idx, prog_q.size());
    check({tag, ".ready_run"},  f_ready(s), 0);
    check({tag, ".load_count"}, lc_v[s], prog_q.size());

    k = 0; aborted = 1'b0;
    while (done_v[s] !== 1'b1 && k < to + 5) begin
      k++;
      if (k == rst_at) begin
        set_dmem(s, 1'b0, '0, '0);
        rst_n = 1'b0;
        #1;
        check_reset(s, {tag, ".midrun"});
        @(negedge clk);
        rst_n = 1'b1;
        aborted = 1'b1;
        break;
      end
      if (cpu_rst_v[s] !== 1'b0) bad_rst++;
      set_dmem(s, sch_we[k], sch_addr[k], sch_data[k]);
      @(negedge clk);
    end
    set_dmem(s, 1'b0, '0, '0);

    if (!aborted) begin
      check({tag, ".done"},        done_v[s], 1);
      check({tag, ".pass"},        pass_v[s], exp_pass);
      check({tag, ".timeout"},     to_v[s], exp_to);
      check({tag, ".cycle_count"}, cc_v[s], exp_cyc);
      check({tag, ".run_cycles"},  k, exp_cyc);
      check({tag, ".cpu_rst_done"}, cpu_rst_v[s], 1);
      check({tag, ".busy_done"},   busy_v[s], 0);
      check({tag, ".cpu_rst_seq"}, bad_rst, 0);
      nw = (s == 0) ? wq0.size() : wq1.size();
      check({tag, ".n_writes"}, nw, prog_q.size());
      for (int i = 0; i < prog_q.size() && i < nw; i++) begin
        w = (s == 0) ? wq0[i] : wq1[i];
        exp_addr = IAW'((int'((s == 0) ? BASE_A : BASE_B) + i) % (1 << IAW));
        check({tag, ".waddr"}, w[IAW+IW-1:IW], exp_addr);
        check({tag, ".wdata"}, w[IW-1:0], prog_q[i]);
      end
      repeat (3) @(negedge clk);
      check({tag, ".hold_done"}, done_v[s], 1);
      check({tag, ".hold_cc"},   cc_v[s], exp_cyc);
    end
  endtask

  initial begin
    start_v = '0; ea_v = '0; ed_v = '0;
    set_load(0, 1'b0, '0, 1'b0); set_load(1, 1'b0, '0, 1'b0);
    set_dmem(0, 1'b0, '0, '0);   set_dmem(1, 1'b0, '0, '0);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset(0, "init_a");
    check_reset(1, "init_b");
    rst_n = 1'b1;
    @(negedge clk);

    // sum-to-10 style program: the modelled CPU stores 55 to address 100
    fill_prog(10);
    build_sched(10'd100, 48'd55, 0, $urandom_range(5, 40));
    session(0, 0, 10'd100, 48'd55, -1, -1, "sum_pass");
    build_sched(10'd100, 48'd55, 0, $urandom_range(5, 40));
    session(0, 0, 10'd100, 48'd56, -1, -1, "sum_wrong");

    fill_prog(6);
    build_sched(10'd100, 48'd0, 2, 1);
    session(0, 2, 10'd100, 48'd55, -1, -1, "timeout");

    fill_prog(4);
    build_sched(10'd77, 48'h1234_5678_9abc, 0, $urandom_range(1, 20));
    session(0, 1, 10'd77, 48'h1234_5678_9abc, -1, -1, "gaps");

    fill_prog(3);
    build_sched(10'd5, 48'hdead, 0, TO_A);
    session(0, 0, 10'd5, 48'hdead, -1, -1, "hit_at_timeout");

    fill_prog(8);
    build_sched(10'd100, 48'd0, 2, 1);
    session(0, 2, 10'd100, 48'd55, 20, -1, "reset_midrun");
    check_reset(1, "reset_midrun_b");
    fill_prog(10);
    build_sched(10'd100, 48'd55, 0, $urandom_range(5, 40));
    session(0, 0, 10'd100, 48'd55, -1, -1, "after_reset");

    fill_prog(4);
    build_sched(10'd300, 48'hbeef, 0, $urandom_range(1, 30));
    session(1, 0, 10'd300, 48'hbeef, -1, 2, "wrap_start_ign");

    for (int r = 0; r < 3; r++) begin
      logic [DAW-1:0] ea;
      logic [DW-1:0]  ed;
      int mode;
      ea = DAW'($urandom);
      ed = DW'({$urandom, $urandom});
      mode = $urandom_range(0, 2);
      fill_prog($urandom_range(1, 12));
      build_sched(ea, (mode == 1) ? (ed ^ DW'(1)) : ed, mode, $urandom_range(1, 60));
      session(1, 2, ea, ed, -1, -1, $sformatf("rand%0d", r));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, observed running expected finished");
    $fatal(1, "watchdog expired");
  end

endmodule
